// File: rtl/conv2d_stream.sv
`default_nettype none
// ============================================================================
// conv2d_stream: streaming KxK "valid" 2D convolution using K-1 line buffers
// Revision: 1.0
// ============================================================================
module conv2d_stream #(
  parameter int unsigned         PW     = 8,
  parameter int unsigned         IMG_W  = 640,
  parameter int unsigned         IMG_H  = 360,
  parameter int unsigned         K      = 3,
  parameter int unsigned         CW     = 8,
  // Coefficient i (row-major, 0 = oldest row/col) lives at KERNEL[i*CW +: CW]
  parameter logic [K*K*CW-1:0]   KERNEL = {{4{CW'(0)}}, CW'(1), {4{CW'(0)}}},
  parameter int unsigned         SHIFT  = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  input  logic          sof_i,
  input  logic [PW-1:0] pixel_i,
  output logic          valid_o,
  output logic [PW-1:0] pixel_o,
  output logic          last_o,
  output logic          busy_o
);

  localparam int unsigned c_CLW = $clog2(IMG_W);
  localparam int unsigned c_RLW = $clog2(IMG_H);
  localparam int unsigned c_PRW = PW + 1 + CW;
  localparam int unsigned c_AW  = PW + CW + 1 + $clog2(K * K);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

  state_e             state_q;
  logic [c_CLW-1:0]   col_q, col_d, w_cur_col;
  logic [c_RLW-1:0]   row_q, row_d, w_cur_row;
  logic               w_last_col, w_last_row, w_is_last, w_win_ok;

  logic [PW-1:0]      lb_q  [K-1][IMG_W];
  logic [PW-1:0]      win_q [K][K];
  logic [PW-1:0]      w_colv [K];

  logic signed [c_PRW-1:0] w_prod [K*K];
  logic signed [c_PRW-1:0] prod_q [K*K];
  logic signed [c_AW-1:0]  w_sum, w_shr;
  logic [PW-1:0]           w_sat;

  logic win_vld_q, win_last_q, v1_q, last1_q;

  // sof forces the current pixel to (0,0) irrespective of the running counters
  always_comb begin
    w_cur_col  = sof_i ? '0 : col_q;
    w_cur_row  = sof_i ? '0 : row_q;
    w_last_col = (w_cur_col == c_CLW'(IMG_W - 1));
    w_last_row = (w_cur_row == c_RLW'(IMG_H - 1));
    w_is_last  = w_last_col && w_last_row;
    w_win_ok   = (w_cur_row >= c_RLW'(K - 1)) && (w_cur_col >= c_CLW'(K - 1));
    if (w_last_col) begin
      col_d = '0;
      row_d = w_last_row ? '0 : w_cur_row + c_RLW'(1);
    end else begin
      col_d = w_cur_col + c_CLW'(1);
      row_d = w_cur_row;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(K) - 1; i++) begin
      w_colv[i] = lb_q[i][w_cur_col];
    end
    w_colv[K-1] = pixel_i;
  end

  // Storage that is always written before it is read needs no reset
  always_ff @(posedge clk_i) begin
    if (valid_i) begin
      for (int i = 0; i < int'(K) - 1; i++) begin
        lb_q[i][w_cur_col] <= w_colv[i+1];
      end
      for (int i = 0; i < int'(K); i++) begin
        for (int c = 0; c < int'(K) - 1; c++) begin
          win_q[i][c] <= win_q[i][c+1];
        end
        win_q[i][K-1] <= w_colv[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(K * K); i++) begin
      w_prod[i] = c_PRW'($signed({1'b0, win_q[i/K][i%K]})) *
                  c_PRW'($signed(KERNEL[i*CW +: CW]));
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(K * K); i++) begin
      prod_q[i] <= w_prod[i];
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < int'(K * K); i++) begin
      w_sum = w_sum + c_AW'(prod_q[i]);
    end
    w_shr = w_sum >>> SHIFT;
    if (w_shr[c_AW-1]) begin
      w_sat = '0;
    end else if (|w_shr[c_AW-2:PW]) begin
      w_sat = '1;
    end else begin
      w_sat = w_shr[PW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q      <= '0;
      row_q      <= '0;
      win_vld_q  <= 1'b0;
      win_last_q <= 1'b0;
      v1_q       <= 1'b0;
      last1_q    <= 1'b0;
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      pixel_o    <= '0;
    end else begin
      if (valid_i) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      win_vld_q  <= valid_i & w_win_ok;
      win_last_q <= valid_i & w_is_last;
      v1_q       <= win_vld_q;
      last1_q    <= win_last_q;
      valid_o    <= v1_q;
      last_o     <= v1_q & last1_q;
      if (v1_q) begin
        pixel_o <= w_sat;
      end
    end
  end

  // DRAIN holds busy until the frame's last output has left the pipeline
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ACTIVE: begin
          if (valid_i) state_q <= w_is_last ? S_DRAIN : S_ACTIVE;
        end
        S_DRAIN: begin
          if (valid_i)     state_q <= w_is_last ? S_DRAIN : S_ACTIVE;
          else if (last_o) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream.sv
`default_nettype none
// ============================================================================
// tb_conv2d_stream: directed checks of conv2d_stream over four configurations
// Revision: 1.0
// ============================================================================
module tb_conv2d_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // A: K=2 {1,0,0,1} 4x3; B1/B2: K=2 all +1 / all -1 4x3; D: K=3 all 1 5x4 SHIFT 3
  logic       a_valid, a_sof, a_vo, a_lo, a_busy;
  logic [7:0] a_pix, a_po;
  logic       b_valid, b_sof, b1_vo, b1_lo, b1_busy, b2_vo, b2_lo, b2_busy;
  logic [7:0] b_pix, b1_po, b2_po;
  logic       d_valid, d_sof, d_vo, d_lo, d_busy;
  logic [7:0] d_pix, d_po;

  conv2d_stream #(.PW(8), .IMG_W(4), .IMG_H(3), .K(2), .CW(8),
                  .KERNEL(32'h01000001), .SHIFT(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(a_valid), .sof_i(a_sof), .pixel_i(a_pix),
    .valid_o(a_vo), .pixel_o(a_po), .last_o(a_lo), .busy_o(a_busy));

  conv2d_stream #(.PW(8), .IMG_W(4), .IMG_H(3), .K(2), .CW(8),
                  .KERNEL(32'h01010101), .SHIFT(0)) dut_b1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(b_valid), .sof_i(b_sof), .pixel_i(b_pix),
    .valid_o(b1_vo), .pixel_o(b1_po), .last_o(b1_lo), .busy_o(b1_busy));

  conv2d_stream #(.PW(8), .IMG_W(4), .IMG_H(3), .K(2), .CW(8),
                  .KERNEL(32'hFFFFFFFF), .SHIFT(0)) dut_b2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(b_valid), .sof_i(b_sof), .pixel_i(b_pix),
    .valid_o(b2_vo), .pixel_o(b2_po), .last_o(b2_lo), .busy_o(b2_busy));

  conv2d_stream #(.PW(8), .IMG_W(5), .IMG_H(4), .K(3), .CW(8),
                  .KERNEL(72'h010101010101010101), .SHIFT(3)) dut_d (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(d_valid), .sof_i(d_sof), .pixel_i(d_pix),
    .valid_o(d_vo), .pixel_o(d_po), .last_o(d_lo), .busy_o(d_busy));

  int qa_v[$], qa_c[$], qb1_v[$], qb2_v[$], qd_v[$];
  bit qa_l[$], qb1_l[$], qb2_l[$], qd_l[$];
  int acc[$];

  always @(posedge clk) begin
    #1;
    if (a_vo === 1'b1) begin qa_v.push_back(int'(a_po)); qa_l.push_back(a_lo); qa_c.push_back(cyc); end
    if (b1_vo === 1'b1) begin qb1_v.push_back(int'(b1_po)); qb1_l.push_back(b1_lo); end
    if (b2_vo === 1'b1) begin qb2_v.push_back(int'(b2_po)); qb2_l.push_back(b2_lo); end
    if (d_vo === 1'b1) begin qd_v.push_back(int'(d_po)); qd_l.push_back(d_lo); end
  end

  int n_vec = 0;
  int n_err = 0;
  int T1_V[6] = '{5, 7, 9, 13, 15, 17};
  bit T1_L[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic a_drive(input bit v, input bit s, input int p);
    @(negedge clk);
    a_valid = v; a_sof = s; a_pix = p[7:0];
  endtask

  // Pixels 0..n-1, sof on the first; records accept cycle of pixels that close a window
  task automatic a_frame(input bit gaps, input int n);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) a_drive(1'b0, 1'b0, 0);
      a_drive(1'b1, i == 0, i);
      if (i >= 4 && (i % 4) != 0) acc.push_back(cyc + 1);
    end
    a_drive(1'b0, 1'b0, 0);
  endtask

  // Expected stream: `pre` outputs of 5 from an aborted frame, then the test-1 frame
  task automatic check_a(input string tag, input int pre);
    int ev, el, j;
    chk({tag, "_count"}, qa_v.size(), pre + 6);
    for (int i = 0; i < pre + 6 && i < qa_v.size(); i++) begin
      j  = i - pre;
      ev = (i < pre) ? 5 : T1_V[j];
      el = (i < pre) ? 0 : int'(T1_L[j]);
      chk($sformatf("%s_pix%0d", tag, i), qa_v[i], ev);
      chk($sformatf("%s_last%0d", tag, i), int'(qa_l[i]), el);
      if (i < acc.size()) chk($sformatf("%s_lat%0d", tag, i), qa_c[i] - acc[i], 2);
    end
    qa_v.delete(); qa_l.delete(); qa_c.delete(); acc.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 0; a_sof = 0; a_pix = 0;
    b_valid = 0; b_sof = 0; b_pix = 0;
    d_valid = 0; d_sof = 0; d_pix = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(a_vo), 0);
    chk("rst_pixel", int'(a_po), 0);
    chk("rst_last",  int'(a_lo), 0);
    chk("rst_busy",  int'(a_busy), 0);
    rst_n = 1'b1;

    // Test 1: back-to-back frame
    a_frame(1'b0, 12);
    chk("t1_busy_drain", int'(a_busy), 1);
    repeat (6) a_drive(1'b0, 1'b0, 0);
    chk("t1_busy_idle", int'(a_busy), 0);
    check_a("t1", 0);

    // Test 2: saturation high / low
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); b_valid = 1'b1; b_sof = (i == 0); b_pix = 8'd255;
    end
    @(negedge clk); b_valid = 1'b0; b_sof = 1'b0;
    repeat (6) @(negedge clk);
    chk("t2_pos_count", qb1_v.size(), 6);
    chk("t2_neg_count", qb2_v.size(), 6);
    for (int i = 0; i < 6 && i < qb1_v.size(); i++) begin
      chk($sformatf("t2_pos_pix%0d", i), qb1_v[i], 255);
      chk($sformatf("t2_pos_last%0d", i), int'(qb1_l[i]), (i == 5) ? 1 : 0);
    end
    for (int i = 0; i < 6 && i < qb2_v.size(); i++) begin
      chk($sformatf("t2_neg_pix%0d", i), qb2_v[i], 0);
      chk($sformatf("t2_neg_last%0d", i), int'(qb2_l[i]), (i == 5) ? 1 : 0);
    end

    // Test 3: K=3 box filter with shift
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); d_valid = 1'b1; d_sof = (i == 0); d_pix = 8'd8;
    end
    @(negedge clk); d_valid = 1'b0; d_sof = 1'b0;
    repeat (6) @(negedge clk);
    chk("t3_count", qd_v.size(), 6);
    for (int i = 0; i < 6 && i < qd_v.size(); i++) begin
      chk($sformatf("t3_pix%0d", i), qd_v[i], 9);
      chk($sformatf("t3_last%0d", i), int'(qd_l[i]), (i == 5) ? 1 : 0);
    end

    // Test 4: random input gaps
    a_frame(1'b1, 12);
    repeat (6) a_drive(1'b0, 1'b0, 0);
    check_a("t4", 0);

    // Test 5: frame aborted by sof after 6 pixels, then a full frame
    a_frame(1'b0, 6);
    a_frame(1'b0, 12);
    repeat (6) a_drive(1'b0, 1'b0, 0);
    check_a("t5", 1);

    // Test 6: asynchronous reset while outputs are in flight
    for (int i = 0; i < 7; i++) a_drive(1'b1, i == 0, i);
    a_drive(1'b0, 1'b0, 0);
    @(posedge clk); #1;
    chk("t6_pre_valid", int'(a_vo), 1);
    chk("t6_pre_pixel", int'(a_po), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(a_vo), 0);
    chk("t6_rst_last",  int'(a_lo), 0);
    chk("t6_rst_busy",  int'(a_busy), 0);
    chk("t6_rst_pixel", int'(a_po), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    qa_v.delete(); qa_l.delete(); qa_c.delete(); acc.delete();
    repeat (4) a_drive(1'b0, 1'b0, 0);
    chk("t6_quiet", qa_v.size(), 0);
    a_frame(1'b0, 12);
    repeat (6) a_drive(1'b0, 1'b0, 0);
    check_a("t6", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
